tree_router_node: RTL and testbench

Clocked, parametrised three-port node for the binary-tree packet network: one parent port, two child ports. Each input has a small FIFO, and each output has a round-robin arbiter and a registered output stage. Routing uses the destination field of the packet and the node's level in the tree. It replaces the untimed single-input switch with a full-duplex node that buffers traffic and resolves contention.

---
 rtl/tree_router_pkg.sv | 45 ++++
 rtl/tree_router_node_fifo.sv | 53 +++++
 rtl/tree_router_node.sv | 146 ++++++++++++++
 tb/tb_tree_router_node.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tree_router_pkg.sv
// Shared definitions for the binary-tree router node: port indices and routing helpers.
// Latency: none (pure functions).
// Backpressure: not applicable.
package tree_router_pkg;

    localparam logic [1:0] PORT_PARENT = 2'd0;
    localparam logic [1:0] PORT_C0     = 2'd1;
    localparam logic [1:0] PORT_C1     = 2'd2;

    // Widest packet / address field the helpers can carry.
    localparam int MAX_PKT_W  = 512;
    localparam int MAX_ADDR_W = 16;

    function automatic logic [MAX_ADDR_W-1:0] dest_field(
        input logic [MAX_PKT_W-1:0] pkt,
        input int                   lsb,
        input int                   w
    );
        logic [MAX_PKT_W-1:0] mask;
        logic [MAX_PKT_W-1:0] shifted;
        mask    = (MAX_PKT_W'(1) << w) - MAX_PKT_W'(1);
        shifted = (pkt >> lsb) & mask;
        return shifted[MAX_ADDR_W-1:0];
    endfunction

    // Parent traffic always descends; child traffic descends only when its
    // destination lies inside this node's subtree, otherwise it climbs.
    function automatic logic [1:0] route_dir(
        input logic                  from_parent,
        input logic [MAX_ADDR_W-1:0] dest,
        input logic [MAX_ADDR_W-1:0] node_addr,
        input int                    w,
        input int                    level
    );
        logic [MAX_ADDR_W-1:0] sel_vec;
        logic                  prefix_ok;
        sel_vec   = dest >> (w - 1 - level);
        prefix_ok = (level == 0) || ((dest >> (w - level)) == (node_addr >> (w - level)));
        if (from_parent || prefix_ok) begin
            return sel_vec[0] ? PORT_C1 : PORT_C0;
        end
        return PORT_PARENT;
    endfunction

endpackage

// File: rtl/tree_router_node_fifo.sv
// Synchronous input FIFO (DEPTH entries, power of two) with full/empty flags.
// Latency: a pushed word is visible at the head one cycle later.
// Backpressure: push ignored while full; caller gates push with !full.
module router_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("router_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Extra pointer bit distinguishes full from empty when the indices meet.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/tree_router_node.sv
// Three-port tree router node (parent, child0, child1); optional TREE_ROUTER_STATS_EN adds pkt_cnt.
// Latency: one cycle from input acceptance to out_valid; one packet/cycle/output.
// Backpressure: in_ready = !fifo_full (registered); output register holds while !out_ready.
module tree_router_node
    import tree_router_pkg::*;
#(
    parameter int                WIDTH     = 32,
    parameter int                ADDR_W    = 3,
    parameter int                ADDR_LSB  = 24,
    parameter int                LEVEL     = 0,
    parameter logic [ADDR_W-1:0] NODE_ADDR = '0,
    parameter int                DEPTH     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0][WIDTH-1:0] in_data,
    input  logic [2:0]            in_valid,
    output logic [2:0]            in_ready,
    output logic [2:0][WIDTH-1:0] out_data,
    output logic [2:0]            out_valid,
    input  logic [2:0]            out_ready
`ifdef TREE_ROUTER_STATS_EN
    ,
    output logic [2:0][15:0]      pkt_cnt
`endif
);

    if (LEVEL < 0 || LEVEL >= ADDR_W) begin : g_bad_level
        $error("tree_router_node: LEVEL must be in 0..ADDR_W-1");
    end
    if (ADDR_W > MAX_ADDR_W || WIDTH > MAX_PKT_W || ADDR_LSB + ADDR_W > WIDTH) begin : g_bad_geom
        $error("tree_router_node: address field does not fit the packet");
    end

    localparam logic [MAX_ADDR_W-1:0] NODE_EXT = MAX_ADDR_W'(NODE_ADDR);

    logic                  rdy_q;
    logic [2:0][WIDTH-1:0] head;
    logic [2:0]            full;
    logic [2:0]            empty;
    logic [2:0]            pop;
    logic [2:0][1:0]       dir;
    logic [2:0][2:0]       grant;   // [output][input]

    // Keeps in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_in
        router_fifo #(
            .WIDTH(WIDTH),
            .DEPTH(DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst_n    (rst_n),
            .push     (in_valid[i] && in_ready[i]),
            .push_data(in_data[i]),
            .pop      (pop[i]),
            .head     (head[i]),
            .full     (full[i]),
            .empty    (empty[i])
        );

        assign in_ready[i] = rdy_q && !full[i];
        assign dir[i]      = route_dir((i == 0),
                                       dest_field(MAX_PKT_W'(head[i]), ADDR_LSB, ADDR_W),
                                       NODE_EXT, ADDR_W, LEVEL);
        // Each head requests exactly one output, so it can win at most once.
        assign pop[i]      = grant[0][i] | grant[1][i] | grant[2][i];
    end

    for (genvar o = 0; o < 3; o++) begin : g_out
        logic [2:0]       req;
        logic [2:0]       cand;
        logic [1:0]       ptr;
        logic [WIDTH-1:0] data_q;
        logic             vld_q;
        logic             load;

        for (genvar i = 0; i < 3; i++) begin : g_req
            assign req[i] = !empty[i] && (dir[i] == 2'(o));
        end

        assign load = !vld_q || out_ready[o];

        always_comb begin
            cand = 3'b000;
            case (ptr)
                2'd1: begin
                    if (req[1])      cand = 3'b010;
                    else if (req[2]) cand = 3'b100;
                    else if (req[0]) cand = 3'b001;
                end
                2'd2: begin
                    if (req[2])      cand = 3'b100;
                    else if (req[0]) cand = 3'b001;
                    else if (req[1]) cand = 3'b010;
                end
                default: begin
                    if (req[0])      cand = 3'b001;
                    else if (req[1]) cand = 3'b010;
                    else if (req[2]) cand = 3'b100;
                end
            endcase
        end

        assign grant[o] = load ? cand : 3'b000;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ptr    <= 2'd0;
                data_q <= '0;
                vld_q  <= 1'b0;
            end else if (|grant[o]) begin
                vld_q  <= 1'b1;
                data_q <= cand[0] ? head[0] : (cand[1] ? head[1] : head[2]);
                ptr    <= cand[0] ? 2'd1 : (cand[1] ? 2'd2 : 2'd0);
            end else if (out_ready[o]) begin
                vld_q  <= 1'b0;
            end
        end

        assign out_valid[o] = vld_q;
        assign out_data[o]  = data_q;

`ifdef TREE_ROUTER_STATS_EN
        logic [15:0] cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= 16'd0;
            end else if (vld_q && out_ready[o] && cnt != 16'hFFFF) begin
                cnt <= cnt + 16'd1;
            end
        end

        assign pkt_cnt[o] = cnt;
`endif
    end

endmodule

// File: tb/tb_tree_router_node.sv
// Bench for tree_router_node: a LEVEL=1 node (NODE_ADDR=100) and a root node, directed steps plus random traffic.
// Expected routing and ordering come from a per-(source,output) queue model of the routing rules.
module tb_tree_router_node;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [2:0][31:0] ida, oda, idb, odb;
    logic [2:0]      iva, ira, ova, rdya;
    logic [2:0]      ivb, irb, ovb, rdyb;
    logic [2:0][15:0] pca, pcb;

    tree_router_node #(.WIDTH(32), .ADDR_W(3), .ADDR_LSB(24), .LEVEL(1),
                       .NODE_ADDR(3'b100), .DEPTH(2)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_data(ida), .in_valid(iva), .in_ready(ira),
        .out_data(oda), .out_valid(ova), .out_ready(rdya)
`ifdef TREE_ROUTER_STATS_EN
        , .pkt_cnt(pca)
`endif
    );

    tree_router_node #(.WIDTH(32), .ADDR_W(3), .ADDR_LSB(24), .LEVEL(0),
                       .NODE_ADDR(3'b000), .DEPTH(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_data(idb), .in_valid(ivb), .in_ready(irb),
        .out_data(odb), .out_valid(ovb), .out_ready(rdyb)
`ifdef TREE_ROUTER_STATS_EN
        , .pkt_cnt(pcb)
`endif
    );

`ifndef TREE_ROUTER_STATS_EN
    assign pca = '0;
    assign pcb = '0;
`endif

    int checks = 0;
    int failures = 0;
    int seq = 0;

    logic [31:0]      sb [2][3][3][$];   // [dut][source][output]
    logic [2:0]       pst [2];
    logic [2:0][31:0] pdat [2];
    logic [2:0]       acca, accb;
    int               order [$];
    logic [2:0]       rr_dest [3] = '{3'b000, 3'b100, 3'b101};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // dut 0: LEVEL=1, NODE_ADDR=100 -> subtree is dest[2]==1. dut 1: root.
    function automatic int route(int u, int src, logic [2:0] d);
        if (u == 1) return d[2] ? 2 : 1;
        if (src == 0 || d[2] == 1'b1) return d[1] ? 2 : 1;
        return 0;
    endfunction

    function automatic logic [31:0] mk(int src, logic [2:0] d);
        logic [31:0] p;
        p = {5'($urandom), d, 2'(src), 6'($urandom), 16'(seq)};
        seq++;
        return p;
    endfunction

    function automatic int pending(int u);
        int n = 0;
        for (int i = 0; i < 3; i++)
            for (int o = 0; o < 3; o++)
                n += sb[u][i][o].size();
        return n;
    endfunction

    task automatic eval(input int u, input logic [2:0][31:0] id, input logic [2:0] iv,
                        input logic [2:0] ir, input logic [2:0][31:0] od,
                        input logic [2:0] ov, input logic [2:0] rdy, output logic [2:0] acc);
        for (int i = 0; i < 3; i++) begin
            acc[i] = iv[i] && ir[i];
            if (acc[i]) sb[u][i][route(u, i, id[i][26:24])].push_back(id[i]);
        end
        for (int o = 0; o < 3; o++) begin
            if (pst[u][o]) begin
                chk("hold_valid", 64'(ov[o]), 64'd1);
                chk("hold_data", 64'(od[o]), 64'(pdat[u][o]));
            end
            if (ov[o] && rdy[o]) begin
                int s = int'(od[o][23:22]);
                checks++;
                assert (s < 3 && sb[u][s][o].size() != 0) else begin
                    failures++;
                    $error("FAIL stray_pkt dut=%0d port=%0d observed=%h expected=none_queued", u, o, od[o]);
                end
                if (s < 3 && sb[u][s][o].size() != 0)
                    chk("route_data", 64'(od[o]), 64'(sb[u][s][o].pop_front()));
            end
            pst[u][o]  = ov[o] && !rdy[o];
            pdat[u][o] = od[o];
        end
        if (u == 1) chk("root_parent_idle", 64'(ov[0]), 64'd0);
    endtask

    task automatic tick();
        eval(0, ida, iva, ira, oda, ova, rdya, acca);
        eval(1, idb, ivb, irb, odb, ovb, rdyb, accb);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        iva = '0;
        ivb = '0;
        #1;
        chk("rst_out_valid", 64'({ova, ovb}), 64'd0);
        chk("rst_in_ready_low", 64'({ira, irb}), 64'd0);
        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < 3; i++)
                for (int o = 0; o < 3; o++)
                    sb[u][i][o].delete();
            pst[u] = '0;
        end
        acca = '0;
        accb = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready_release", 64'({ira, irb}), 64'h3f);
        chk("rst_out_data", 64'(oda[0] | oda[1] | oda[2]), 64'd0);
`ifdef TREE_ROUTER_STATS_EN
        chk("rst_pkt_cnt_a", 64'(pca), 64'd0);
        chk("rst_pkt_cnt_b", 64'(pcb), 64'd0);
`endif
        tick();
        chk("rst_fifo_empty", 64'({ova, ovb}), 64'd0);
    endtask

    initial begin
        logic [31:0] p, q;
        int n;
        rst_n = 1'b1;
        ida = '0; idb = '0; iva = '0; ivb = '0;
        rdya = '1; rdyb = '1;
        acca = '0; accb = '0;
        pst[0] = '0; pst[1] = '0;
        @(negedge clk);
        do_reset();

        // Parent -> child1, one-cycle latency, data unchanged.
        p = mk(0, 3'b110);
        ida[0] = p; iva = 3'b001;
        tick();
        iva = '0;
        chk("lat_not_early", 64'(ova), 64'd0);
        tick();
        chk("lat_valid", 64'(ova), 64'b100);
        chk("lat_data", 64'(oda[2]), 64'(p));
        tick();
`ifdef TREE_ROUTER_STATS_EN
        chk("pkt_cnt_one", 64'(pca[2]), 64'd1);
`endif

        // Child0 -> parent (outside subtree), then child0 -> child0 U-turn.
        p = mk(1, 3'b010);
        ida[1] = p; iva = 3'b010;
        tick();
        q = mk(1, 3'b101);
        ida[1] = q;
        tick();
        iva = '0;
        chk("to_parent_valid", 64'(ova), 64'b001);
        chk("to_parent_data", 64'(oda[0]), 64'(p));
        tick();
        chk("uturn_valid", 64'(ova), 64'b010);
        chk("uturn_data", 64'(oda[1]), 64'(q));
        tick();

        // Root node: both children to child1, parent never used.
        p = mk(1, 3'b110);
        q = mk(2, 3'b101);
        idb[1] = p; idb[2] = q; ivb = 3'b110;
        tick();
        ivb = '0;
        tick();
        chk("root_first_valid", 64'(ovb), 64'b100);
        chk("root_first_data", 64'(odb[2]), 64'(p));
        tick();
        chk("root_second_valid", 64'(ovb), 64'b100);
        chk("root_second_data", 64'(odb[2]), 64'(q));
        tick();

        // Three persistent requesters for child0: strict rotation, no bubbles.
        do_reset();
        order.delete();
        for (int k = 0; k < 11; k++) begin
            for (int i = 0; i < 3; i++)
                if (!iva[i] || acca[i]) begin
                    iva[i] = 1'b1;
                    ida[i] = mk(i, rr_dest[i]);
                end
            if (ova[1] && rdya[1]) order.push_back(int'(oda[1][23:22]));
            tick();
        end
        iva = '0;
        chk("rr_grant_count", 64'(order.size()), 64'd9);
        for (int k = 0; k < order.size() && k < 9; k++)
            chk("rr_order", 64'(order[k]), 64'(k % 3));
        repeat (8) tick();
        chk("rr_drained", 64'(pending(0)), 64'd0);

        // Stalled child1 output: 2 in FIFO + 1 in output register.
        do_reset();
        rdya = 3'b011;
        n = 0;
        for (int k = 0; k < 6; k++) begin
            if (!iva[0] || acca[0]) begin
                iva[0] = 1'b1;
                ida[0] = mk(0, 3'b010);
            end
            tick();
            n += int'(acca[0]);
        end
        chk("bp_accepted", 64'(n), 64'd3);
        chk("bp_in_ready", 64'(ira[0]), 64'd0);
        rdya = '1;
        iva = '0;
        repeat (8) tick();
        chk("bp_drained", 64'(pending(0)), 64'd0);

        // Random traffic on both nodes with a reset in the middle.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            if (k == 200) do_reset();
            for (int i = 0; i < 3; i++) begin
                if (!(iva[i] && !acca[i])) begin
                    iva[i] = 1'($urandom_range(0, 1));
                    ida[i] = mk(i, 3'($urandom));
                end
                if (!(ivb[i] && !accb[i])) begin
                    ivb[i] = 1'($urandom_range(0, 1));
                    idb[i] = mk(i, 3'($urandom));
                end
                rdya[i] = ($urandom_range(0, 3) != 0);
                rdyb[i] = ($urandom_range(0, 3) != 0);
            end
            tick();
        end
        iva = '0; ivb = '0;
        rdya = '1; rdyb = '1;
        repeat (12) tick();
        chk("rand_drained_a", 64'(pending(0)), 64'd0);
        chk("rand_drained_b", 64'(pending(1)), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
